// File: rtl/roi_frame_server.sv
// rtl/roi_frame_server.sv - ROI window pixel server streaming a sub-window of a full-frame buffer
// Optional macro ROI_TEST_PATTERN_EN adds test_mode, replacing memory pixels by {x,y,8'h5A}.
module roi_frame_server #(
    parameter int FRAME_W    = 1280,
    parameter int FRAME_H    = 480,
    parameter int ADDR_W     = 20,
    parameter int VSYNC_LEN  = 4,
    parameter int HBLANK_LEN = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ARMImgRequest,
    input  logic [10:0]       HorMinIn,
    input  logic [10:0]       HorMaxIn,
    input  logic [8:0]        VerMinIn,
    input  logic [8:0]        VerMaxIn,
`ifdef ROI_TEST_PATTERN_EN
    input  logic              test_mode,
`endif
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [23:0]       mem_data,
    output logic [23:0]       pixel_out,
    output logic              de_out,
    output logic              vsync_out,
    output logic              busy,
    output logic              frame_done,
    output logic              req_error
);

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_ROW, S_HBLANK, S_DONE} state_t;

    localparam logic [10:0]       X_LAST   = 11'(FRAME_W - 1);
    localparam logic [8:0]        Y_LAST   = 9'(FRAME_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FRAME_W);
    localparam logic [7:0]        VS_LAST  = 8'(VSYNC_LEN - 1);
    localparam logic [7:0]        HB_LAST  = 8'(HBLANK_LEN - 1);

    state_t            state_q;
    logic              req_q, busy_q, req_error_q, mem_rd_en_q;
    logic [ADDR_W-1:0] mem_addr_q, row_base_q;
    logic [10:0]       x_q, hmin_q, hmax_q;
    logic [8:0]        y_q, vmax_q;
    logic [7:0]        cnt_q;
    logic              de1_q, vs1_q, last1_q;
    logic              de_out_q, vsync_out_q, frame_done_q;
    logic [23:0]       pixel_out_q;

    logic [10:0]       hmax_d;
    logic [8:0]        vmax_d;
    logic              win_ok_d, req_rise_d, rd_allow;
    logic [ADDR_W-1:0] row_base_d;
    logic              gen_de, gen_vs, gen_last;
    logic [23:0]       px_src;

    always_comb begin
        hmax_d     = (HorMaxIn > X_LAST) ? X_LAST : HorMaxIn;
        vmax_d     = (VerMaxIn > Y_LAST) ? Y_LAST : VerMaxIn;
        win_ok_d   = (HorMinIn <= hmax_d) && (VerMinIn <= vmax_d) &&
                     (HorMinIn <= X_LAST) && (VerMinIn <= Y_LAST);
        req_rise_d = ARMImgRequest & ~req_q;
        row_base_d = row_base_q + ROW_STEP;
        gen_de     = (state_q == S_ROW);
        gen_vs     = (state_q == S_VSYNC);
        gen_last   = gen_de && (x_q == hmax_q) && (y_q == vmax_q);
    end

`ifdef ROI_TEST_PATTERN_EN
    logic        tm1_q;
    logic [23:0] pat1_q;
    assign rd_allow = ~test_mode;
    always_comb px_src = tm1_q ? pat1_q : mem_data;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tm1_q  <= 1'b0;
            pat1_q <= '0;
        end else begin
            tm1_q  <= test_mode;
            pat1_q <= {x_q[7:0], y_q[7:0], 8'h5A};
        end
    end
`else
    assign rd_allow = 1'b1;
    always_comb px_src = mem_data;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            req_error_q <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            row_base_q  <= '0;
            x_q         <= '0;
            hmin_q      <= '0;
            hmax_q      <= '0;
            y_q         <= '0;
            vmax_q      <= '0;
            cnt_q       <= '0;
        end else begin
            req_q       <= ARMImgRequest;
            req_error_q <= 1'b0;
            case (state_q)
                S_IDLE: if (req_rise_d) begin
                    hmin_q     <= HorMinIn;
                    hmax_q     <= hmax_d;
                    vmax_q     <= vmax_d;
                    y_q        <= VerMinIn;
                    row_base_q <= ADDR_W'(VerMinIn) * ROW_STEP;
                    cnt_q      <= '0;
                    if (win_ok_d) begin
                        state_q <= S_VSYNC;
                        busy_q  <= 1'b1;
                    end else begin
                        req_error_q <= 1'b1;
                    end
                end
                S_VSYNC: if (cnt_q == VS_LAST) begin
                    state_q     <= S_ROW;
                    x_q         <= hmin_q;
                    mem_rd_en_q <= rd_allow;
                    mem_addr_q  <= row_base_q + ADDR_W'(hmin_q);
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
                S_ROW: if (x_q == hmax_q) begin
                    state_q     <= S_HBLANK;
                    cnt_q       <= '0;
                    mem_rd_en_q <= 1'b0;
                end else begin
                    x_q        <= x_q + 11'd1;
                    mem_addr_q <= row_base_q + ADDR_W'(x_q + 11'd1);
                end
                S_HBLANK: if (cnt_q == HB_LAST) begin
                    if (y_q == vmax_q) begin
                        state_q <= S_DONE;
                    end else begin
                        state_q     <= S_ROW;
                        y_q         <= y_q + 9'd1;
                        row_base_q  <= row_base_d;
                        x_q         <= hmin_q;
                        mem_rd_en_q <= rd_allow;
                        mem_addr_q  <= row_base_d + ADDR_W'(hmin_q);
                    end
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
                S_DONE: if (!de1_q && !vs1_q && !last1_q && !de_out_q && !frame_done_q) begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Two stages: one for the synchronous memory read, one for the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de1_q        <= 1'b0;
            vs1_q        <= 1'b0;
            last1_q      <= 1'b0;
            de_out_q     <= 1'b0;
            vsync_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
            pixel_out_q  <= '0;
        end else begin
            de1_q        <= gen_de;
            vs1_q        <= gen_vs;
            last1_q      <= gen_last;
            de_out_q     <= de1_q;
            vsync_out_q  <= vs1_q;
            frame_done_q <= last1_q;
            pixel_out_q  <= de1_q ? px_src : 24'h0;
        end
    end

    assign mem_rd_en  = mem_rd_en_q;
    assign mem_addr   = mem_addr_q;
    assign pixel_out  = pixel_out_q;
    assign de_out     = de_out_q;
    assign vsync_out  = vsync_out_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign req_error  = req_error_q;

endmodule

// File: doc/roi_frame_server.md
Name: roi_frame_server

Overview:
- Synthesizable responder for the image_in_ROI pixel request.
- On an ARMImgRequest it latches the requested window and reads those pixels from a full-frame buffer through a synchronous read port.
- It streams the window row-major on pixel_out/de_out/vsync_out, the same stream format image_in_ROI consumes.
- Replaces the behavioural ARM emulator in the hardware build.

Parameters:
- FRAME_W, 1280, stored frame width in pixels.
- FRAME_H, 480, stored frame height in lines.
- ADDR_W, 20, frame-buffer address width; must satisfy FRAME_W*FRAME_H <= 2^ADDR_W.
- VSYNC_LEN, 4, vsync pulse length in cycles before the first row.
- HBLANK_LEN, 8, de-low gap after every row, including the last.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- ARMImgRequest  in  1  request; rising edge starts a frame.
- HorMinIn  in  11  window first column, inclusive.
- HorMaxIn  in  11  window last column, inclusive.
- VerMinIn  in  9  window first line, inclusive.
- VerMaxIn  in  9  window last line, inclusive.
- mem_rd_en  out  1  frame-buffer read enable.
- mem_addr  out  ADDR_W  read address = y*FRAME_W + x.
- mem_data  in  24  read data, valid exactly 1 cycle after mem_rd_en.
- pixel_out  out  24  window pixel.
- de_out  out  1  pixel valid.
- vsync_out  out  1  frame start pulse.
- busy  out  1  frame in progress; requests are ignored while high.
- frame_done  out  1  one-cycle pulse, coincident with the last de_out cycle.
- req_error  out  1  one-cycle pulse when a window is rejected.

Behaviour:
- Reset state: every output is 0, FSM is IDLE, the request edge register is 0 (a request held high through reset release counts as a rising edge), and the delay line is cleared.
- Reset asserted mid-frame aborts immediately. No frame_done is issued.
- Request capture: the rising edge is detected on a registered copy of ARMImgRequest. The bounds are latched in the same cycle.
- Bound clamping: HorMax is clamped to FRAME_W-1 and VerMax to FRAME_H-1.
- Window rejection: if HorMin > HorMax or VerMin > VerMax after clamping, or HorMin >= FRAME_W or VerMin >= FRAME_H, pulse req_error one cycle after the edge and stay in IDLE. No vsync is emitted.
- FSM IDLE: go to VSYNC on a valid request; busy rises with this transition.
- FSM VSYNC: generator vsync high for VSYNC_LEN cycles, then ROW with x=HorMin, y=VerMin.
- FSM ROW: mem_rd_en=1 and mem_addr=y*FRAME_W+x each cycle; x increments. When x==HorMax, go to HBLANK.
- FSM HBLANK: HBLANK_LEN idle cycles. Then, if y==VerMax, go to DONE; else y+1, x=HorMin, ROW.
- FSM DONE: wait for the delay line to drain, then IDLE with busy low.
- Address arithmetic: use a row-base register, initialised to VerMin*FRAME_W (one multiply at latch time) and incremented by FRAME_W per row. Add x. No per-pixel multiplier.
- Output alignment: generator de/vsync/last flags pass through a 2-stage delay line (memory latency 1 + output register 1).
- Output timing: pixel_out <= mem_data registered, so de_out, pixel_out, vsync_out and frame_done appear 2 cycles after the generating cycle.
- Idle pixel value: pixel_out = 0 whenever de_out = 0.
- Output counts: exactly (HorMax-HorMin+1)*(VerMax-VerMin+1) de_out cycles; each row is a contiguous de burst.
- Degenerate window: a 1x1 window is legal and yields one pixel, with frame_done on that cycle.
- Request handling while busy: requests while busy=1 are dropped, not queued. A request rising in the same cycle busy falls is also dropped; a new edge is needed.

Optional Feature:
- Macro: ROI_TEST_PATTERN_EN.
- When defined: extra input test_mode (1 bit). With test_mode=1, pixel_out = {x[7:0], y[7:0], 8'h5A}, delay-aligned, and mem_rd_en stays 0.
- When undefined: no port, no pattern logic; pixels always come from mem_data.

Test Plan:
- Basic frame: memory preloaded with data = address[23:0]; window x 10..12, y 5..6.
  - 4 vsync cycles, then rows 6410,6411,6412 and 7690,7691,7692.
  - 8-cycle gaps between rows; frame_done with pixel 7692.
- Large window: window 149x73, as used by the downstream img_out check (x 400..548, y 100..172).
  - Exactly 10877 de cycles, 73 bursts of 149.
  - First pixel is addr 128400.
- Rejection: HorMin=20, HorMax=10.
  - req_error pulses once, no vsync, no de, busy stays 0.
- Clamp: HorMax=2000, VerMax=511, HorMin=1278, VerMin=478.
  - 2x2 output: addrs 613118, 613119, 614398, 614399.
- Mid-frame abort and busy handling:
  - Reset asserted during row 3 → all outputs 0 next cycle.
  - A second request pulse while busy → ignored, only one frame_done.
- Pattern mode: with ROI_TEST_PATTERN_EN defined, test_mode=1, window x 3..3, y 7..7.
  - Single pixel 24'h03075A; mem_rd_en never asserted.
